ins_fetcher: RTL and testbench

- Producer side of the instruction queue.
- Issues word fetches to the memory controller at the current PC.
- Pushes each returned instruction with its PC into the queue, honouring the queue's full flag.
- On a pipeline clear, redirects to the clear target and discards any in-flight fetch.

---
 rtl/ins_fetcher.sv | 118 +++++++++++
 tb/tb_ins_fetcher.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ins_fetcher.sv
// Instruction fetcher: fetches words at PC and pushes {ins, pc} into the instruction queue.
// Latency: mem_req 1 cycle after IDLE, push 1 cycle after mem_done; backpressure via queue full flag (HOLD).
// Optional `INS_FETCHER_JAL_PREDICT_EN: follow JAL targets instead of pc+4.
module ins_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          INS_W    = 32,
  parameter int          PC_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             clear,
  input  logic [PC_W-1:0]  clear_pc,
  output logic             mem_req,
  output logic [PC_W-1:0]  mem_addr,
  input  logic             mem_done,
  input  logic [INS_W-1:0] mem_data,
  input  logic             full,
  output logic             push,
  output logic [INS_W-1:0] push_ins,
  output logic [PC_W-1:0]  push_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [INS_W-1:0] hold_ins;
  logic [INS_W-1:0] push_src;
  logic [PC_W-1:0]  pc_next;

  // The word being pushed comes from the hold register only when leaving HOLD.
  assign push_src = (state == HOLD) ? hold_ins : mem_data;

`ifdef INS_FETCHER_JAL_PREDICT_EN
  logic            is_jal;
  logic [PC_W-1:0] j_imm;

  assign is_jal  = (push_src[6:0] == 7'b1101111);
  assign j_imm   = {{(PC_W-20){push_src[31]}}, push_src[19:12], push_src[20],
                    push_src[30:21], 1'b0};
  assign pc_next = is_jal ? (pc + j_imm) : (pc + PC_W'(4));
`else
  assign pc_next = pc + PC_W'(4);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= PC_W'(RESET_PC);
      mem_req  <= 1'b0;
      mem_addr <= PC_W'(RESET_PC);
      push     <= 1'b0;
      push_ins <= '0;
      push_pc  <= '0;
      hold_ins <= '0;
    end else if (clear) begin
      push     <= 1'b0;
      mem_req  <= 1'b0;
      pc       <= clear_pc;
      mem_addr <= clear_pc;
      // An outstanding fetch must still be absorbed before refetching.
      case (state)
        WAIT:    state <= mem_done ? IDLE : DRAIN;
        DRAIN:   state <= DRAIN;
        default: state <= IDLE;
      endcase
    end else if (ready) begin
      case (state)
        IDLE: begin
          push <= 1'b0;
          if (!full) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            if (!full) begin
              push     <= 1'b1;
              push_ins <= push_src;
              push_pc  <= pc;
              pc       <= pc_next;
              state    <= IDLE;
            end else begin
              hold_ins <= mem_data;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!full) begin
            push     <= 1'b1;
            push_ins <= push_src;
            push_pc  <= pc;
            pc       <= pc_next;
            state    <= IDLE;
          end else begin
            push <= 1'b0;
          end
        end
        DRAIN: begin
          mem_req <= 1'b0;
          if (mem_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed self-checking bench for ins_fetcher.
module tb_ins_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        clear;
  logic [31:0] clear_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        full;
  logic        push;
  logic [31:0] push_ins;
  logic [31:0] push_pc;

  int checks = 0;
  int errors = 0;

  ins_fetcher #(.RESET_PC(32'h0), .INS_W(32), .PC_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .clear    (clear),
    .clear_pc (clear_pc),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_done (mem_done),
    .mem_data (mem_data),
    .full     (full),
    .push     (push),
    .push_ins (push_ins),
    .push_pc  (push_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch from IDLE with a memory that answers one cycle after seeing the request.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    step();
    chk("fetch_req", 32'(mem_req), 32'd1);
    chk("fetch_addr", mem_addr, addr);
    chk("fetch_push_lo", 32'(push), 32'd0);
    step();
    chk("fetch_req_held", 32'(mem_req), 32'd1);
    mem_done = 1'b1;
    mem_data = data;
    step();
    mem_done = 1'b0;
    chk("fetch_push", 32'(push), 32'd1);
    chk("fetch_push_ins", push_ins, data);
    chk("fetch_push_pc", push_pc, addr);
    chk("fetch_req_drop", 32'(mem_req), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    ready    = 1'b1;
    clear    = 1'b0;
    clear_pc = 32'h0;
    mem_done = 1'b0;
    mem_data = 32'h0;
    full     = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_push_ins", push_ins, 32'h0);
    chk("rst_push_pc", push_pc, 32'h0);
    reset = 1'b0;

    // Streaming NOPs at 0, 4, 8 then 0xC: one push every 3 cycles
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 32'h00000013);

    // full in IDLE blocks the request
    full = 1'b1;
    step();
    chk("idle_full_req", 32'(mem_req), 32'd0);
    chk("idle_full_push", 32'(push), 32'd0);
    full = 1'b0;
    step();
    chk("full_rel_req", 32'(mem_req), 32'd1);
    chk("full_rel_addr", mem_addr, 32'h10);

    // Response arrives while full: held until the queue drains
    full = 1'b1;
    step();
    mem_done = 1'b1;
    mem_data = 32'hDEADBEEF;
    step();
    mem_done = 1'b0;
    chk("hold_push0", 32'(push), 32'd0);
    chk("hold_req0", 32'(mem_req), 32'd0);
    step();
    step();
    chk("hold_push1", 32'(push), 32'd0);
    full = 1'b0;
    step();
    chk("hold_push", 32'(push), 32'd1);
    chk("hold_push_ins", push_ins, 32'hDEADBEEF);
    chk("hold_push_pc", push_pc, 32'h10);
    step();
    chk("hold_after_push", 32'(push), 32'd0);
    chk("hold_next_req", 32'(mem_req), 32'd1);
    chk("hold_next_addr", mem_addr, 32'h14);

    // Clear while the 0x14 fetch is outstanding; late response is dropped
    clear    = 1'b1;
    clear_pc = 32'h100;
    step();
    clear = 1'b0;
    chk("clr_req", 32'(mem_req), 32'd0);
    chk("clr_addr", mem_addr, 32'h100);
    chk("clr_push", 32'(push), 32'd0);
    step();
    step();
    mem_done = 1'b1;
    mem_data = 32'hBADBAD00;
    step();
    mem_done = 1'b0;
    chk("drain_push", 32'(push), 32'd0);
    chk("drain_req", 32'(mem_req), 32'd0);
    step();
    chk("redir_req", 32'(mem_req), 32'd1);
    chk("redir_addr", mem_addr, 32'h100);
    chk("redir_push", 32'(push), 32'd0);

    // ready low during a push pulse freezes everything
    step();
    mem_done = 1'b1;
    mem_data = 32'h11111111;
    step();
    mem_done = 1'b0;
    chk("stall_push_start", 32'(push), 32'd1);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_push", 32'(push), 32'd1);
      chk("stall_push_ins", push_ins, 32'h11111111);
      chk("stall_push_pc", push_pc, 32'h100);
      chk("stall_req", 32'(mem_req), 32'd0);
      chk("stall_addr", mem_addr, 32'h100);
    end
    ready = 1'b1;
    step();
    chk("unstall_push", 32'(push), 32'd0);
    chk("unstall_req", 32'(mem_req), 32'd1);
    chk("unstall_addr", mem_addr, 32'h104);

    // Asynchronous reset mid-WAIT
    reset = 1'b1;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_push", 32'(push), 32'd0);
    chk("arst_addr", mem_addr, 32'h0);
    step();
    reset = 1'b0;

    // Walk to 0x20 and push a JAL (+8)
    for (int i = 0; i < 8; i++) fetch(32'(i * 4), 32'h00000013);
    fetch(32'h20, 32'h0080006F);
    step();
    chk("jal_req", 32'(mem_req), 32'd1);
`ifdef INS_FETCHER_JAL_PREDICT_EN
    chk("jal_next_addr", mem_addr, 32'h28);
`else
    chk("jal_next_addr", mem_addr, 32'h24);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
